rsa_modexp_ctrl: RTL and testbench



---
 rtl/alu_defs_pkg.sv | 7 +
 rtl/rsa_modexp_ctrl_pkg.sv | 19 +
 rtl/alu.sv | 29 ++
 rtl/rsa_modexp_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/alu_defs_pkg.sv
// Opcode encodings shared by the CPU ALU and every block that drives it.
package alu_defs;
   localparam logic [2:0] ARITH_ADD = 3'b000;
   localparam logic [2:0] ARITH_SUB = 3'b001;
   localparam logic [2:0] ARITH_MUL = 3'b010;
   localparam logic [2:0] MOV_      = 3'b011;
endpackage

// File: rtl/rsa_modexp_ctrl_pkg.sv
// State and reduction return-target types for the modular exponentiation sequencer.
package rsa_ctrl_defs;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_LOADB  = 3'd2,
      ST_REDUCE = 3'd3,
      ST_SQR    = 3'd4,
      ST_MULB   = 3'd5,
      ST_NEXT   = 3'd6,
      ST_DONE   = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      RET_BASE    = 2'd0,
      RET_ACC_SQR = 2'd1,
      RET_ACC_MUL = 2'd2
   } ret_t;
endpackage

// File: rtl/alu.sv
// Shared N-bit combinational ALU: add/sub/mul/mov with {negative, zero} flags.
module alu
   import alu_defs::*;
#(
   parameter int N = 16
) (
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] result,
   output logic [1:0]   flags
);

   // Operation select; the product is truncated to N bits.
   always_comb begin
      case (op)
         ARITH_ADD: result = a + b;
         ARITH_SUB: result = a - b;
         ARITH_MUL: result = a * b;
         MOV_:      result = b;
         default:   result = {N{1'b0}};
      endcase
   end

   // Flags derived from the result.
   always_comb begin
      flags = {result[N-1], (result == {N{1'b0}})};
   end
endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod m on a shared ALU,
// one ALU operation per cycle, with reduction by repeated subtraction.
module rsa_modexp_ctrl
   import alu_defs::*;
   import rsa_ctrl_defs::*;
#(
   parameter int N = 16,
   parameter int E = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [N-1:0] base_i,
   input  logic [E-1:0] exp_i,
   input  logic [N-1:0] mod_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o,
   output logic [N-1:0] result_o,
   output logic [N-1:0] alu_a_o,
   output logic [N-1:0] alu_b_o,
   output logic [2:0]   alu_op_o,
   input  logic [N-1:0] alu_result_i,
   input  logic [1:0]   alu_flags_i
);

   localparam int BW = (E > 1) ? $clog2(E) : 1;
   localparam logic [BW-1:0] BIT_TOP  = BW'(E - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);
   localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
   localparam logic [N-1:0]  ZERO     = {N{1'b0}};
   localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]  TWO      = {{(N-2){1'b0}}, 2'b10};

   state_t        state_r, state_s;
   ret_t          ret_r, ret_s;
   logic [N-1:0]  acc_r, acc_s;
   logic [N-1:0]  tmp_r, tmp_s;
   logic [N-1:0]  base_r, base_s;
   logic [N-1:0]  m_r, m_s;
   logic [E-1:0]  exp_r, exp_s;
   logic [BW-1:0] bit_r, bit_s;
   logic [N-1:0]  result_s;
   logic          busy_s, done_s, err_s;
   logic [N-1:0]  alu_a_s, alu_b_s;
   logic [2:0]    alu_op_s;

   // Next-state and datapath register updates; ALU results are captured as the issuing state ends.
   always_comb begin
      state_s  = state_r;
      ret_s    = ret_r;
      acc_s    = acc_r;
      tmp_s    = tmp_r;
      base_s   = base_r;
      m_s      = m_r;
      exp_s    = exp_r;
      bit_s    = bit_r;
      result_s = result_o;
      busy_s   = busy_o;
      done_s   = 1'b0;
      err_s    = err_o;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               base_s  = base_i;
               exp_s   = exp_i;
               m_s     = mod_i;
               err_s   = 1'b0;
               busy_s  = 1'b1;
               state_s = ST_CHECK;
            end else begin
               busy_s  = 1'b0;
            end
         end
         ST_CHECK: begin
            if (m_r < TWO) begin
               err_s    = 1'b1;
               result_s = ZERO;
               done_s   = 1'b1;
               state_s  = ST_DONE;
            end else begin
               acc_s    = ONE;
               bit_s    = BIT_TOP;
               state_s  = ST_LOADB;
            end
         end
         ST_LOADB: begin
            tmp_s   = alu_result_i;
            ret_s   = RET_BASE;
            state_s = ST_REDUCE;
         end
         // A negative SUB means tmp is already below m; otherwise keep subtracting.
         ST_REDUCE: begin
            if (alu_flags_i[1]) begin
               case (ret_r)
                  RET_BASE: begin
                     base_s  = tmp_r;
                     state_s = ST_SQR;
                  end
                  RET_ACC_SQR: begin
                     acc_s   = tmp_r;
                     state_s = exp_r[bit_r] ? ST_MULB : ST_NEXT;
                  end
                  RET_ACC_MUL: begin
                     acc_s   = tmp_r;
                     state_s = ST_NEXT;
                  end
                  default: begin
                     busy_s  = 1'b0;
                     state_s = ST_IDLE;
                  end
               endcase
            end else begin
               tmp_s = alu_result_i;
            end
         end
         ST_SQR: begin
            tmp_s   = alu_result_i;
            ret_s   = RET_ACC_SQR;
            state_s = ST_REDUCE;
         end
         ST_MULB: begin
            tmp_s   = alu_result_i;
            ret_s   = RET_ACC_MUL;
            state_s = ST_REDUCE;
         end
         ST_NEXT: begin
            if (bit_r == BIT_ZERO) begin
               result_s = acc_r;
               done_s   = 1'b1;
               state_s  = ST_DONE;
            end else begin
               bit_s    = bit_r - BIT_ONE;
               state_s  = ST_SQR;
            end
         end
         ST_DONE: begin
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
         default: begin
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // ALU command for the state being entered, so the registered outputs line up with that state.
   always_comb begin
      alu_op_s = MOV_;
      alu_a_s  = ZERO;
      alu_b_s  = ZERO;
      case (state_s)
         ST_LOADB: begin
            alu_op_s = MOV_;
            alu_b_s  = base_s;
         end
         ST_REDUCE: begin
            alu_op_s = ARITH_SUB;
            alu_a_s  = tmp_s;
            alu_b_s  = m_s;
         end
         ST_SQR: begin
            alu_op_s = ARITH_MUL;
            alu_a_s  = acc_s;
            alu_b_s  = acc_s;
         end
         ST_MULB: begin
            alu_op_s = ARITH_MUL;
            alu_a_s  = acc_s;
            alu_b_s  = base_s;
         end
         default: begin
            alu_op_s = MOV_;
            alu_a_s  = ZERO;
            alu_b_s  = ZERO;
         end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r  <= ST_IDLE;
         ret_r    <= RET_BASE;
         acc_r    <= ZERO;
         tmp_r    <= ZERO;
         base_r   <= ZERO;
         m_r      <= ZERO;
         exp_r    <= {E{1'b0}};
         bit_r    <= BIT_ZERO;
         result_o <= ZERO;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         err_o    <= 1'b0;
         alu_a_o  <= ZERO;
         alu_b_o  <= ZERO;
         alu_op_o <= MOV_;
      end else begin
         state_r  <= state_s;
         ret_r    <= ret_s;
         acc_r    <= acc_s;
         tmp_r    <= tmp_s;
         base_r   <= base_s;
         m_r      <= m_s;
         exp_r    <= exp_s;
         bit_r    <= bit_s;
         result_o <= result_s;
         busy_o   <= busy_s;
         done_o   <= done_s;
         err_o    <= err_s;
         alu_a_o  <= alu_a_s;
         alu_b_o  <= alu_b_s;
         alu_op_o <= alu_op_s;
      end
   end
endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Directed and randomized checks of the modexp sequencer driving the shared ALU,
// against a plain-arithmetic square-and-multiply reference.
module tb_rsa_modexp_ctrl;
   import alu_defs::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] base = 16'd0;
   logic [15:0] expo = 16'd0;
   logic [15:0] modv = 16'd0;
   logic        busy, done, err;
   logic [15:0] result, alu_a, alu_b, alu_result;
   logic [2:0]  alu_op;
   logic [1:0]  alu_flags;

   int n_assert = 0;
   int n_fail   = 0;

   rsa_modexp_ctrl #(.N(16), .E(16)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .base_i(base), .exp_i(expo), .mod_i(modv),
      .busy_o(busy), .done_o(done), .err_o(err), .result_o(result),
      .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
      .alu_result_i(alu_result), .alu_flags_i(alu_flags)
   );

   alu #(.N(16)) u_alu (
      .op(alu_op), .a(alu_a), .b(alu_b), .result(alu_result), .flags(alu_flags)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_modexp(input int unsigned b, input int unsigned e,
                                              input int unsigned m);
      longint unsigned r, x;
      if (m < 2) return 16'd0;
      r = 1 % m;
      x = b % m;
      for (int i = 15; i >= 0; i--) begin
         r = (r * r) % m;
         if (((e >> i) & 1) == 1) r = (r * x) % m;
      end
      return 16'(r);
   endfunction

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle start; inputs are scrambled afterwards to prove they were latched.
   task automatic start_op(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
      start = 1'b1; base = b; expo = e; modv = m;
      step();
      start = 1'b0;
      base = 16'($urandom); expo = 16'($urandom); modv = 16'($urandom);
      chk1("busy_after_start", busy, 1'b1);
      chk1("err_cleared_on_start", err, 1'b0);
   endtask

   task automatic wait_done(input int limit, output int cyc);
      logic busy_ok;
      busy_ok = 1'b1;
      cyc = 0;
      while (done !== 1'b1 && cyc < limit) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         step();
         cyc++;
      end
      chk1("done_seen", done, 1'b1);
      chk1("busy_through_op", busy_ok, 1'b1);
      chk1("busy_at_done", busy, 1'b1);
   endtask

   task automatic finish_pulse();
      step();
      chk1("done_single_pulse", done, 1'b0);
      chk1("busy_dropped", busy, 1'b0);
      chk16("alu_idle_op", {13'd0, alu_op}, {13'd0, MOV_});
      chk16("alu_idle_a", alu_a, 16'd0);
      chk16("alu_idle_b", alu_b, 16'd0);
   endtask

   task automatic run_op(input string tag, input logic [15:0] b, input logic [15:0] e,
                         input logic [15:0] m, input logic [15:0] expv);
      int cyc;
      start_op(b, e, m);
      wait_done(20000, cyc);
      chk16(tag, result, expv);
      chk1("err_low", err, 1'b0);
      finish_pulse();
   endtask

   initial begin
      int cyc;
      logic no_done;
      logic [15:0] rb, re, rm;

      repeat (3) step();
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk16("rst_result", result, 16'd0);
      chk16("rst_alu_op", {13'd0, alu_op}, {13'd0, MOV_});
      chk16("rst_alu_a", alu_a, 16'd0);
      rst = 1'b0;
      step();

      run_op("4^13_mod_97", 16'd4, 16'd13, 16'd97, 16'd93);

      run_op("9^7_mod_143", 16'd9, 16'd7, 16'd143, 16'd48);
      repeat (5) step();
      chk16("result_held", result, 16'd48);
      run_op("48^103_mod_143", 16'd48, 16'd103, 16'd143, 16'd9);

      run_op("200^1_mod_7", 16'd200, 16'd1, 16'd7, 16'd4);
      run_op("5^0_mod_11", 16'd5, 16'd0, 16'd11, 16'd1);
      run_op("0^5_mod_11", 16'd0, 16'd5, 16'd11, 16'd0);

      // Bad modulus: done in the third cycle counting the start cycle, start during DONE ignored.
      start_op(16'd7, 16'd3, 16'd1);
      wait_done(50, cyc);
      chk16("err_latency", 16'(cyc), 16'd1);
      chk1("err_set", err, 1'b1);
      chk16("err_result", result, 16'd0);
      start = 1'b1; base = 16'd2; expo = 16'd2; modv = 16'd5;
      step();
      start = 1'b0;
      chk1("start_in_done_ignored", busy, 1'b0);
      chk1("err_held", err, 1'b1);
      step();
      chk1("still_idle", busy, 1'b0);
      run_op("err_clear_3^4_mod_7", 16'd3, 16'd4, 16'd7, 16'd4);

      // Restart attempt mid-operation must be ignored.
      start_op(16'd4, 16'd13, 16'd97);
      repeat (20) step();
      start = 1'b1; base = 16'd3; expo = 16'd5; modv = 16'd11;
      step();
      start = 1'b0;
      wait_done(20000, cyc);
      chk16("ignored_restart", result, 16'd93);
      finish_pulse();

      // Reset while reducing aborts without done.
      start_op(16'd48, 16'd103, 16'd143);
      cyc = 0;
      while (alu_op !== ARITH_SUB && cyc < 200) begin
         step();
         cyc++;
      end
      chk16("reached_reduce", {13'd0, alu_op}, {13'd0, ARITH_SUB});
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk1("midrst_busy", busy, 1'b0);
      chk1("midrst_done", done, 1'b0);
      chk1("midrst_err", err, 1'b0);
      chk16("midrst_result", result, 16'd0);
      chk16("midrst_alu_op", {13'd0, alu_op}, {13'd0, MOV_});
      chk16("midrst_alu_a", alu_a, 16'd0);
      chk16("midrst_alu_b", alu_b, 16'd0);
      no_done = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
         step();
      end
      chk1("no_done_after_rst", no_done, 1'b1);
      run_op("3^96_mod_97", 16'd3, 16'd96, 16'd97, 16'd1);

      for (int k = 0; k < 5; k++) begin
         rm = 16'($urandom_range(182, 2));
         rb = 16'($urandom_range(1023, 0));
         re = 16'($urandom);
         run_op("random_modexp", rb, re, rm, ref_modexp(rb, re, rm));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
